calc_ctrl: RTL
==============

CALC_CTRL -- requirements
Module: calc_ctrl

Interface
REQ-001 clk  in  1  single system clock; all state changes on its rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 key_valid  in  1  one-cycle key strobe.
REQ-004 key_type  in  2  00 digit, 01 operator, 10 equals, 11 clear.
REQ-005 key_val  in  4  digit value (0-15) or operator code in bits [1:0].
REQ-006 alu_done  in  1  one-cycle pulse; result valid on the memory's res input.
REQ-007 alu_err  in  1  qualified by alu_done; 1 = invalid result (e.g. divide by zero).
REQ-008 key_ready  out  1  1 = a non-clear key is accepted this cycle.
REQ-009 num  out  4  digit forwarded to memory.
REQ-010 operator  out  2  operator forwarded to memory.
REQ-011 save_enable  out  2  memory command: 01 save1, 10 operator, 11 save2, 00 none.
REQ-012 clear_enable / equ_enable / op_enable  out  1 each  memory strobes.
REQ-013 alu_start  out  1  one-cycle compute request.
REQ-014 disp_sel  out  2  00 show save1, 01 show save2, 10 show error.

Function
REQ-015 All outputs shall be registered; a key sampled at edge N shall produce its command in the cycle after edge N+1, lasting exactly one cycle. All strobes and save_enable shall otherwise be 0.
REQ-016 States: INIT, OPA, OPB_WAIT, OPB, CALC, RESULT, RELOAD, ERR.
REQ-017 INIT: clear_enable=1 for one cycle, then OPA with both digit counters at 0.
REQ-018 key_ready shall be 0 in INIT, CALC and RELOAD, and 1 otherwise; non-clear keys with key_ready=0 shall be dropped without effect.
REQ-019 Clear key: accepted in every state.
  - Issues clear_enable=1.
  - Zeroes both digit counters.
  - Sets disp_sel=00, goes to OPA.
  - In CALC, it also aborts the computation; a later alu_done shall be ignored.
REQ-020 OPA handling:
  - digit with cntA<4: save_enable=01, num=key_val, cntA+1.
  - digit with cntA=4: ignored (16-bit limit).
  - operator: save_enable=10, op_enable=1, operator=key_val[1:0], go to OPB_WAIT, disp_sel=01.
  - equals: ignored.
REQ-021 OPB_WAIT handling:
  - digit: save_enable=11, num=key_val, cntB=1, go to OPB.
  - operator: re-issue save_enable=10 with the new code (last operator wins).
  - equals: ignored.
REQ-022 OPB handling:
  - digit with cntB<4: save_enable=11, cntB+1; with cntB=4: ignored.
  - operator: ignored.
  - equals: alu_start=1, go to CALC.
REQ-023 CALC waits for alu_done with no timeout.
  - alu_err=0: save_enable=01, equ_enable=1 in the same cycle, disp_sel=00, go to RESULT.
  - alu_err=1: disp_sel=10, go to ERR, no memory write.
REQ-024 RESULT handling:
  - digit: store key_val internally, issue clear_enable=1, go to RELOAD.
  - In RELOAD (next cycle): save_enable=01, num=stored digit, cntA=1, go to OPA.
  - operator and equals: ignored (chaining unsupported; save2 cannot be cleared independently).
REQ-025 ERR: all keys except clear shall be ignored.
REQ-026 alu_done outside CALC shall be ignored.
REQ-027 At most one memory command per cycle; clear_enable shall never coincide with a nonzero save_enable.

Reset
REQ-028 While rst=1: state=INIT, counters=0, all outputs 0, disp_sel=00, key_ready=0.
REQ-029 First cycle after rst deassertion: clear_enable=1.
REQ-030 rst asserted mid-operation (any state, including CALC) shall return to the REQ-028 values immediately, without waiting for a clock.

Verification
REQ-031 Reset release, keys 1,2 (digit), op 01, digit 3, equals, alu_done (err=0) -> sequence:
  - clear_enable
  - save_enable 01 num=1, then 01 num=2
  - 10 op=01 with op_enable
  - 11 num=3
  - alu_start
  - 01 with equ_enable
  - disp_sel=00, state RESULT.
REQ-032 Five digits 9 in OPA -> exactly four save_enable=01 pulses; fifth dropped.
REQ-033 Ops 00 then 11 in OPB_WAIT -> two save_enable=10 pulses, last operator=11; then equals -> no alu_start.
REQ-034 alu_done with alu_err=1 in CALC -> disp_sel=10, no save_enable; digit ignored; clear -> clear_enable, OPA.
REQ-035 Digit 7 in RESULT -> clear_enable one cycle, then save_enable=01 num=7; key_ready=0 during RELOAD.
REQ-036 rst pulsed while in CALC, then alu_done -> outputs zero during rst; clear_enable after release; alu_done causes no write.

Source files
------------

// File: rtl/calc_ctrl.sv
// calc_ctrl: key-driven calculator controller. Keys are registered for one
// cycle, then decoded by the FSM. The resulting memory, ALU and display
// commands are registered outputs.
module calc_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [1:0] key_type,
  input  logic [3:0] key_val,
  input  logic       alu_done,
  input  logic       alu_err,
  output logic       key_ready,
  output logic [3:0] num,
  output logic [1:0] operator,
  output logic [1:0] save_enable,
  output logic       clear_enable,
  output logic       equ_enable,
  output logic       op_enable,
  output logic       alu_start,
  output logic [1:0] disp_sel
);

  typedef enum logic [2:0] {
    S_INIT, S_OPA, S_OPB_WAIT, S_OPB, S_CALC, S_RESULT, S_RELOAD, S_ERR
  } state_t;

  localparam logic [1:0] K_DIG = 2'b00;
  localparam logic [1:0] K_OP  = 2'b01;
  localparam logic [1:0] K_EQ  = 2'b10;
  localparam logic [1:0] K_CLR = 2'b11;

  state_t     state, state_n;
  logic [2:0] cnt_a, cnt_a_n, cnt_b, cnt_b_n;
  logic [3:0] hold, hold_n;

  logic       kv_q;
  logic [1:0] kt_q;
  logic [3:0] kval_q;

  logic [1:0] sav_n, oper_n, disp_n;
  logic [3:0] num_n;
  logic       clr_n, equ_n, open_n, start_n, ready_n;

  logic is_dig, is_op, is_eq, is_clr;

  assign is_dig = kv_q && (kt_q == K_DIG);
  assign is_op  = kv_q && (kt_q == K_OP);
  assign is_eq  = kv_q && (kt_q == K_EQ);
  assign is_clr = kv_q && (kt_q == K_CLR);

  // Key capture stage; non-clear keys are dropped while key_ready is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kv_q   <= 1'b0;
      kt_q   <= '0;
      kval_q <= '0;
    end else begin
      kv_q   <= key_valid && (key_ready || (key_type == K_CLR));
      kt_q   <= key_type;
      kval_q <= key_val;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_INIT;
      cnt_a        <= '0;
      cnt_b        <= '0;
      hold         <= '0;
      key_ready    <= 1'b0;
      num          <= '0;
      operator     <= '0;
      save_enable  <= '0;
      clear_enable <= 1'b0;
      equ_enable   <= 1'b0;
      op_enable    <= 1'b0;
      alu_start    <= 1'b0;
      disp_sel     <= '0;
    end else begin
      state        <= state_n;
      cnt_a        <= cnt_a_n;
      cnt_b        <= cnt_b_n;
      hold         <= hold_n;
      key_ready    <= ready_n;
      num          <= num_n;
      operator     <= oper_n;
      save_enable  <= sav_n;
      clear_enable <= clr_n;
      equ_enable   <= equ_n;
      op_enable    <= open_n;
      alu_start    <= start_n;
      disp_sel     <= disp_n;
    end
  end

  // Next state, digit counters and held reload digit
  always_comb begin
    state_n = state;
    cnt_a_n = cnt_a;
    cnt_b_n = cnt_b;
    hold_n  = hold;
    if (is_clr) begin
      state_n = S_OPA;
      cnt_a_n = '0;
      cnt_b_n = '0;
    end else begin
      case (state)
        S_INIT: begin
          state_n = S_OPA;
          cnt_a_n = '0;
          cnt_b_n = '0;
        end
        S_OPA: begin
          if (is_dig && (cnt_a < 3'd4)) cnt_a_n = cnt_a + 3'd1;
          if (is_op) state_n = S_OPB_WAIT;
        end
        S_OPB_WAIT: begin
          if (is_dig) begin
            cnt_b_n = 3'd1;
            state_n = S_OPB;
          end
        end
        S_OPB: begin
          if (is_dig && (cnt_b < 3'd4)) cnt_b_n = cnt_b + 3'd1;
          if (is_eq) state_n = S_CALC;
        end
        S_CALC: begin
          if (alu_done) state_n = alu_err ? S_ERR : S_RESULT;
        end
        S_RESULT: begin
          if (is_dig) begin
            hold_n  = kval_q;
            state_n = S_RELOAD;
          end
        end
        S_RELOAD: begin
          cnt_a_n = 3'd1;
          state_n = S_OPA;
        end
        S_ERR: ;
        default: state_n = S_INIT;
      endcase
    end
  end

  // Next values of the registered command outputs
  always_comb begin
    sav_n   = '0;
    clr_n   = 1'b0;
    equ_n   = 1'b0;
    open_n  = 1'b0;
    start_n = 1'b0;
    num_n   = num;
    oper_n  = operator;
    disp_n  = disp_sel;
    ready_n = !((state_n == S_INIT) || (state_n == S_CALC) || (state_n == S_RELOAD));
    if (is_clr) begin
      clr_n  = 1'b1;
      disp_n = 2'b00;
    end else begin
      case (state)
        S_INIT: clr_n = 1'b1;
        S_OPA: begin
          if (is_dig && (cnt_a < 3'd4)) begin
            sav_n = 2'b01;
            num_n = kval_q;
          end
          if (is_op) begin
            sav_n  = 2'b10;
            open_n = 1'b1;
            oper_n = kval_q[1:0];
            disp_n = 2'b01;
          end
        end
        S_OPB_WAIT: begin
          if (is_dig) begin
            sav_n = 2'b11;
            num_n = kval_q;
          end
          if (is_op) begin
            sav_n  = 2'b10;
            open_n = 1'b1;
            oper_n = kval_q[1:0];
          end
        end
        S_OPB: begin
          if (is_dig && (cnt_b < 3'd4)) begin
            sav_n = 2'b11;
            num_n = kval_q;
          end
          if (is_eq) start_n = 1'b1;
        end
        S_CALC: begin
          if (alu_done) begin
            if (alu_err) begin
              disp_n = 2'b10;
            end else begin
              sav_n  = 2'b01;
              equ_n  = 1'b1;
              disp_n = 2'b00;
            end
          end
        end
        S_RESULT: begin
          if (is_dig) clr_n = 1'b1;
        end
        S_RELOAD: begin
          sav_n = 2'b01;
          num_n = hold;
        end
        default: ;
      endcase
    end
  end

endmodule
